// File: rtl/keypad_scan_fsm.sv
// keypad_scan_fsm: 4x4 keypad row scanner with press/release debounce and one-hot key report.
module keypad_scan_fsm #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       press,
  output logic       change
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;
  state_t state_q, state_d;
  logic [3:0] sync_q, scols_q;
  logic [3:0] cap_q, cap_d, rows_q, rows_d;
  logic [3:0] key_row_q, key_row_d, key_col_q, key_col_d;
  logic [1:0] idx_q, idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] deb_q, deb_d;
  logic press_q, press_d, change_q, change_d;
  logic dwell_end, deb_end, any_low, cap_open, advance, capture;
  logic [3:0] first_low;
  assign dwell_end = dwell_q == DWELL_LAST;
  assign deb_end   = deb_q == DEB_LAST;
  assign any_low   = ~&scols_q;
  assign cap_open  = |(~cap_q & scols_q);
  assign first_low = !scols_q[0] ? 4'b1110 : !scols_q[1] ? 4'b1101 :
                     !scols_q[2] ? 4'b1011 : 4'b0111;
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= 4'b1111;
      scols_q   <= 4'b1111;
      state_q   <= SCAN;
      idx_q     <= 2'd0;
      rows_q    <= 4'b1110;
      dwell_q   <= '0;
      deb_q     <= '0;
      cap_q     <= 4'b1111;
      key_row_q <= 4'b1111;
      key_col_q <= 4'b1111;
      press_q   <= 1'b0;
      change_q  <= 1'b0;
    end else begin
      sync_q    <= cols;
      scols_q   <= sync_q;
      state_q   <= state_d;
      idx_q     <= idx_d;
      rows_q    <= rows_d;
      dwell_q   <= dwell_d;
      deb_q     <= deb_d;
      cap_q     <= cap_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
      press_q   <= press_d;
      change_q  <= change_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:      state_d = dwell_end && any_low ? DEB_PRESS : SCAN;
      DEB_PRESS: state_d = cap_open ? SCAN : deb_end ? HELD : DEB_PRESS;
      HELD:      state_d = cap_open ? DEB_REL : HELD;
      DEB_REL:   state_d = !cap_open ? HELD : deb_end ? SCAN : DEB_REL;
      default:   state_d = SCAN;
    endcase
  end
  // Row advances on an empty dwell, an aborted press, or a completed release.
  always_comb begin
    advance   = (state_q == SCAN && dwell_end && !any_low) ||
                (state_q == DEB_PRESS && cap_open) ||
                (state_q == DEB_REL && state_d == SCAN);
    capture   = state_q == DEB_PRESS && state_d == HELD;
    idx_d     = advance ? idx_q + 2'd1 : idx_q;
    rows_d    = ~(4'b0001 << idx_d);
    dwell_d   = state_q == SCAN && !dwell_end ? dwell_q + 1'b1 : '0;
    deb_d     = state_q inside {DEB_PRESS, DEB_REL} && state_d == state_q ? deb_q + 1'b1 : '0;
    cap_d     = state_q == SCAN && dwell_end && any_low ? first_low : cap_q;
    key_row_d = capture ? rows_q : key_row_q;
    key_col_d = capture ? cap_q : key_col_q;
    change_d  = capture;
    press_d   = capture | (press_q & !(state_q == DEB_REL && state_d == SCAN));
  end
  assign rows    = rows_q;
  assign key_row = key_row_q;
  assign key_col = key_col_q;
  assign press   = press_q;
  assign change  = change_q;
endmodule

// File: tb/tb_keypad_scan_fsm.sv
// tb_keypad_scan_fsm: directed checks of scan order, debounce, key report and reset abort.
module tb_keypad_scan_fsm;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] cols, rows, key_row, key_col;
  logic press, change;
  logic [15:0] keys = '0;
  int n_cmp = 0, n_err = 0, n, hits, first;
  always #5 clk = ~clk;
  // Keypad model: a closed key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !rows[r]) cols[c] = 1'b0;
  end
  keypad_scan_fsm #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .cols(cols), .rows(rows),
    .key_row(key_row), .key_col(key_col), .press(press), .change(change)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_chg(input int bound, output int cnt);
    cnt = 0;
    do begin
      tick;
      cnt++;
    end while (change !== 1'b1 && cnt < bound);
  endtask
  function automatic logic [3:0] row_n(input int i);
    return ~(4'b0001 << i);
  endfunction
  initial begin
    repeat (3) tick;
    chk("rst_rows", rows, 4'b1110);
    chk("rst_key", {key_row, key_col}, 8'hFF);
    chk("rst_flags", {press, change}, 2'b00);
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick;
      chk("idle_rows", rows, row_n((k / 4) % 4));
      chk("idle_flags", {press, change, key_row, key_col}, 10'h0FF);
    end
    keys[2*4+1] = 1'b1;
    wait_chg(40, n);
    chk("press_lat", n, 20);
    chk("press_row", key_row, 4'b1011);
    chk("press_col", key_col, 4'b1101);
    chk("press_lvl", press, 1);
    tick;
    chk("press_pulse", change, 0);
    repeat (10) begin
      tick;
      chk("press_frozen", {rows, change, press}, {4'b1011, 1'b0, 1'b1});
    end
    keys[9] = 1'b0;
    repeat (3) begin
      tick;
      chk("relb_open", {press, change}, 2'b10);
    end
    keys[9] = 1'b1;
    repeat (5) begin
      tick;
      chk("relb_close", {press, change}, 2'b10);
    end
    keys[9] = 1'b0;
    tick;
    n = 0;
    do begin
      tick;
      n++;
    end while (press && n < 30);
    chk("rel_lat", n, 10);
    chk("rel_rows", rows, 4'b0111);
    chk("rel_key", {key_row, key_col}, 8'hBD);
    chk("rel_chg", change, 0);
    keys[3] = 1'b1;
    repeat (9) tick;
    keys[3] = 1'b0;
    tick;
    keys[3] = 1'b1;
    hits = 0;
    first = 0;
    for (int i = 1; i <= 29; i++) begin
      tick;
      if (i == 2) chk("bounce_abort_rows", rows, 4'b1101);
      if (change) begin
        hits++;
        if (first == 0) first = i;
      end
    end
    chk("bounce_first", first, 26);
    chk("bounce_hits", hits, 1);
    chk("bounce_key", {key_row, key_col}, 8'hE7);
    keys[3] = 1'b0;
    repeat (12) tick;
    chk("bounce_rel", {press, rows}, 5'b0_1101);
    keys[4] = 1'b1;
    keys[6] = 1'b1;
    wait_chg(40, n);
    chk("multi_lat", n, 11);
    chk("multi_key", {key_row, key_col}, 8'hDE);
    keys[15] = 1'b1;
    repeat (20) begin
      tick;
      chk("multi_ignore", {rows, change, press, key_col}, {4'b1101, 2'b01, 4'b1110});
    end
    keys = '0;
    repeat (12) tick;
    chk("multi_rel", {press, rows}, 5'b0_1011);
    keys[9] = 1'b1;
    repeat (8) tick;
    chk("deb_pre", {rows, press, change}, 6'b1011_00);
    reset = 1'b0;
    tick;
    chk("mid_rst_rows", rows, 4'b1110);
    chk("mid_rst_key", {key_row, key_col}, 8'hFF);
    chk("mid_rst_flags", {press, change}, 2'b00);
    reset = 1'b1;
    wait_chg(40, n);
    chk("repress_lat", n, 20);
    chk("repress_key", {key_row, key_col}, 8'hBD);
    tick;
    chk("repress_pulse", change, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
